// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Summary  : Memory-mapped UART transmitter (DATA/STATUS window, TX FIFO, 8N1).
//            Define UART_TX_PARITY_EN to append an even-parity bit to each frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
   parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFE0,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] memAddress,
   input  logic [31:0] memWriteData,
   input  logic        memWrite,
   input  logic [3:0]  byteMask,
   output logic [31:0] memReadData,
   output logic        tx
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH) + 1;
   localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
   localparam logic c_parity_flag = 1'b1;
`else
   localparam logic c_parity_flag = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [c_cnt_w-1:0] r_clk_cnt, w_cnt_nxt;
   logic [2:0]         r_bit_idx, w_bit_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic               r_parity, w_parity_nxt;
   logic               r_tx, w_tx_nxt;

   logic [7:0]         r_fifo [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr, w_count;
   logic [7:0]         r_last_byte, w_fifo_head;
   logic               r_overflow;
   logic               w_hit, w_wr_data, w_wr_status, w_push, w_pop;
   logic               w_full, w_empty, w_busy, w_bit_end;
   logic [3:0]         w_count_sat;
   logic [31:0]        w_status;
   logic               w_unused;

   assign w_hit       = (memAddress >= BASE_MEMORY) && (memAddress <= BASE_MEMORY + 32'd7);
   assign w_wr_data   = w_hit && memWrite && byteMask[0] && !memAddress[2];
   assign w_wr_status = w_hit && memWrite && byteMask[0] &&  memAddress[2];
   // Full is judged before any same-cycle pop, so a write to a full FIFO is always dropped.
   assign w_push      = w_wr_data && !w_full;
   assign w_unused    = ^{memWriteData[31:8], byteMask[3:1]};

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                        (r_wr_ptr[c_ptr_w-2:0] == r_rd_ptr[c_ptr_w-2:0]);
   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_count_sat = (w_count > c_ptr_w'(15)) ? 4'hF : 4'(w_count);
   assign w_fifo_head = r_fifo[r_rd_ptr[c_ptr_w-2:0]];
   assign w_busy      = (r_state != ST_IDLE);
   assign w_status    = {23'd0, c_parity_flag, w_count_sat, r_overflow, w_empty, w_full, w_busy};
   assign tx          = r_tx;

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr[c_ptr_w-2:0]] <= memWriteData[7:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_last_byte <= 8'd0;
         memReadData <= 32'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_data) r_last_byte <= memWriteData[7:0];
         if (w_wr_data && w_full)
            r_overflow <= 1'b1;
         else if (w_wr_status && memWriteData[3])
            r_overflow <= 1'b0;
         memReadData <= w_hit ? (memAddress[2] ? w_status : {24'd0, r_last_byte}) : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_cnt_nxt;
         r_bit_idx <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_parity  <= w_parity_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   // tx is the registered image of the current state's line level (one cycle behind the state).
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_clk_cnt;
      w_bit_nxt    = r_bit_idx;
      w_shift_nxt  = r_shift;
      w_parity_nxt = r_parity;
      w_pop        = 1'b0;
      w_tx_nxt     = 1'b1;
      w_bit_end    = (r_clk_cnt == c_cnt_max);
      if (r_state != ST_IDLE) w_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_shift_nxt  = w_fifo_head;
               w_parity_nxt = ^w_fifo_head;
               w_cnt_nxt    = '0;
               w_bit_nxt    = 3'd0;
               w_state_nxt  = ST_START;
            end
         end
         ST_START: begin
            w_tx_nxt = 1'b0;
            if (w_bit_end) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_bit_end) begin
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_bit_nxt   = r_bit_idx + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            w_tx_nxt = r_parity;
            if (w_bit_end) w_state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (w_bit_end) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire
